// File: rtl/des_sp_stage.sv
// des_sp_stage: registered DES S1/S2 substitution and P permutation slice.
// The S-box lookups and the P wiring are purely combinational; every result
// is captured in the output registers on the same rising clock edge, so the
// slice has a fixed one-cycle latency and never stalls.
//
// Handshake: in_valid qualifies b1, b2 and p_in in the cycle it is high.
// out_valid is a one-cycle-delayed copy of in_valid. There is no ready/backpressure;
// a consumer must take each result in the cycle out_valid is high.
// When in_valid is low the data outputs hold their last loaded values.
module des_sp_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [5:0]  b1,
    input  logic [5:0]  b2,
    input  logic [31:0] p_in,
    output logic [3:0]  s1_out,
    output logic [3:0]  s2_out,
    output logic [31:0] p_out,
    output logic        out_valid
);

    // S-box tables, flattened row-major: entry index = {row[1:0], column[3:0]}.
    localparam logic [3:0] S1_TAB [0:63] = '{
        4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,
        4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
        4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,
        4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
        4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11,
        4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
        4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,
        4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13
    };

    localparam logic [3:0] S2_TAB [0:63] = '{
        4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,
        4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
        4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14,
        4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
        4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,
        4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
        4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,
        4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9
    };

    // P table in DES numbering: output bit (k+1) takes input bit P_TAB[k].
    localparam int P_TAB [0:31] = '{
        16, 7,  20, 21, 29, 12, 28, 17,
        1,  15, 23, 26, 5,  18, 31, 10,
        2,  8,  24, 14, 32, 27, 3,  9,
        19, 13, 30, 6,  22, 11, 4,  25
    };

    logic [3:0]  s1_q, s1_d;
    logic [3:0]  s2_q, s2_d;
    logic [31:0] p_q,  p_d;
    logic        valid_q;
    logic [5:0]  s1_idx, s2_idx;

    // Row uses the outer bits {b[5], b[0]}, column the inner bits b[4:1].
    assign s1_idx = {b1[5], b1[0], b1[4:1]};
    assign s2_idx = {b2[5], b2[0], b2[4:1]};

    // Combinational lookups and P wiring; DES bit n sits at vector index 32-n.
    always_comb begin
        s1_d = S1_TAB[s1_idx];
        s2_d = S2_TAB[s2_idx];
        p_d  = '0;
        for (int k = 0; k < 32; k++) begin
            p_d[31 - k] = p_in[32 - P_TAB[k]];
        end
    end

    // Output registers: reset clears everything, valid loads, otherwise data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
                s2_q <= s2_d;
                p_q  <= p_d;
            end
        end
    end

    assign s1_out    = s1_q;
    assign s2_out    = s2_q;
    assign p_out     = p_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_des_sp_stage.sv
// Testbench for des_sp_stage: directed corner cases plus randomized traffic
// checked against a behavioural model built from the DES tables.
module tb_des_sp_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [5:0]  b1;
  logic [5:0]  b2;
  logic [31:0] p_in;
  logic [3:0]  s1_out;
  logic [3:0]  s2_out;
  logic [31:0] p_out;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  // reference model state (what the outputs should show after the last edge)
  logic [3:0]  m_s1;
  logic [3:0]  m_s2;
  logic [31:0] m_p;
  logic        m_v;

  int s1_tab [4][16] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
    '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
    '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
    '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
  };
  int s2_tab [4][16] = '{
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
    '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
    '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
    '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}
  };
  int p_tab [1:32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                       2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  des_sp_stage dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .b1(b1),
    .b2(b2),
    .p_in(p_in),
    .s1_out(s1_out),
    .s2_out(s2_out),
    .p_out(p_out),
    .out_valid(out_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] sbox_ref(input int which, input logic [5:0] b);
    int row, col;
    row = (b[5] ? 2 : 0) + (b[0] ? 1 : 0);
    col = (int'(b) / 2) % 16;
    if (which == 1) return 4'(s1_tab[row][col]);
    return 4'(s2_tab[row][col]);
  endfunction

  // DES bit n (1 = MSB) of a 32-bit word lives at vector index 32-n.
  function automatic logic [31:0] p_ref(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int n = 1; n <= 32; n++) y[32 - n] = x[32 - p_tab[n]];
    return y;
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the model, and returns 1 time unit
  // after the rising edge so outputs are sampled away from the edge.
  task automatic drive(input logic r, input logic v, input logic [5:0] a,
                       input logic [5:0] b, input logic [31:0] p);
    rst = r; in_valid = v; b1 = a; b2 = b; p_in = p;
    @(posedge clk);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_p = '0; m_v = 1'b0;
    end else begin
      m_v = v;
      if (v) begin
        m_s1 = sbox_ref(1, a);
        m_s2 = sbox_ref(2, b);
        m_p  = p_ref(p);
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 6'h3f, 6'h2a, 32'hdead_beef);
      checks++;
      if ({s1_out, s2_out, p_out, out_valid} !== 41'd0) begin
        errors++;
        $display("FAIL reset_zero cyc%0d: got s1=%0d s2=%0d p=%h v=%b want all 0",
                 i, s1_out, s2_out, p_out, out_valid);
      end
    end
    drive(1'b0, 1'b1, 6'd0, 6'd0, 32'd0);
    checks++;
    if (s1_out !== 4'd14 || s2_out !== 4'd15 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got s1=%0d s2=%0d v=%b want s1=14 s2=15 v=1",
               s1_out, s2_out, out_valid);
    end
  endtask

  task automatic test_sbox_corners();
    logic [5:0] in1 [3] = '{6'b111111, 6'b000001, 6'b100000};
    logic [3:0] ex1 [3] = '{4'd13, 4'd0, 4'd4};
    logic [5:0] in2 [2] = '{6'b111111, 6'b011011};
    logic [3:0] ex2 [2] = '{4'd9, 4'd9};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, in1[i], 6'd0, 32'd0);
      checks++;
      if (s1_out !== ex1[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL s1_corner b1=%b: got %0d v=%b want %0d v=1", in1[i], s1_out, out_valid, ex1[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 6'd0, in2[i], 32'd0);
      checks++;
      if (s2_out !== ex2[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL s2_corner b2=%b: got %0d v=%b want %0d v=1", in2[i], s2_out, out_valid, ex2[i]);
      end
    end
  endtask

  task automatic test_p_bits();
    logic [31:0] pin [4] = '{32'h8000_0000, 32'h0000_0001, 32'hffff_ffff, 32'h0000_0000};
    logic [31:0] pex [4] = '{32'h0080_0000, 32'h0000_0800, 32'hffff_ffff, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 6'd0, 6'd0, pin[i]);
      checks++;
      if (p_out !== pex[i]) begin
        errors++;
        $display("FAIL p_fixed in=%h: got %h want %h", pin[i], p_out, pex[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [31:0] rp;
    for (int i = 0; i < 64; i++) begin
      rp = $urandom;
      drive(1'b0, 1'b1, 6'(i), 6'(i) ^ 6'h2a, rp);
      checks++;
      if (s1_out !== m_s1 || s2_out !== m_s2 || p_out !== m_p || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL exhaustive i=%0d: got s1=%0d s2=%0d p=%h v=%b want s1=%0d s2=%0d p=%h v=1",
                 i, s1_out, s2_out, p_out, out_valid, m_s1, m_s2, m_p);
      end
    end
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b1, 6'd0, 6'd0, 32'd1 << k);
      checks++;
      if (p_out !== m_p || $countones(p_out) != 1) begin
        errors++;
        $display("FAIL p_walk bit%0d: got %h want %h", k, p_out, m_p);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 6'd0, 6'd0, 32'h1234_5678);
    checks++;
    if (s1_out !== 4'd14) begin
      errors++;
      $display("FAIL hold_load: got s1=%0d want 14", s1_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 6'b111111, 6'b111111, $urandom);
      checks++;
      if (s1_out !== 4'd14 || out_valid !== 1'b0 || s2_out !== m_s2 || p_out !== m_p) begin
        errors++;
        $display("FAIL hold cyc%0d: got s1=%0d s2=%0d p=%h v=%b want s1=14 s2=%0d p=%h v=0",
                 i, s1_out, s2_out, p_out, out_valid, m_s2, m_p);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 6'd7, 6'd9, 32'hcafe_f00d);
    drive(1'b1, 1'b1, 6'd5, 6'd5, 32'h5555_aaaa);
    checks++;
    if ({s1_out, s2_out, p_out, out_valid} !== 41'd0) begin
      errors++;
      $display("FAIL reset_mid: got s1=%0d s2=%0d p=%h v=%b want all 0",
               s1_out, s2_out, p_out, out_valid);
    end
    drive(1'b0, 1'b1, 6'd33, 6'd17, 32'h0f0f_3c3c);
    checks++;
    if (s1_out !== m_s1 || s2_out !== m_s2 || p_out !== m_p || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: got s1=%0d s2=%0d p=%h v=%b want s1=%0d s2=%0d p=%h v=1",
               s1_out, s2_out, p_out, out_valid, m_s1, m_s2, m_p);
    end
  endtask

  task automatic test_random();
    logic r, v;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) == 0);
      v = $urandom_range(0, 1);
      drive(r, v, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), $urandom);
      checks++;
      if (s1_out !== m_s1 || s2_out !== m_s2 || p_out !== m_p || out_valid !== m_v) begin
        errors++;
        $display("FAIL random i=%0d: got s1=%0d s2=%0d p=%h v=%b want s1=%0d s2=%0d p=%h v=%b",
                 i, s1_out, s2_out, p_out, out_valid, m_s1, m_s2, m_p, m_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; b1 = '0; b2 = '0; p_in = '0;
    m_s1 = '0; m_s2 = '0; m_p = '0; m_v = 1'b0;
    test_reset();
    test_sbox_corners();
    test_p_bits();
    test_exhaustive();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_sp_stage.md
Name: des_sp_stage

Overview:
- Registered DES substitution/permutation slice for the round-function datapath.
- Performs S-box S1 and S-box S2 lookups and the 32-bit DES P permutation.
- All results are captured in output registers on one clock.
- Sits after the E-expansion/key-XOR stage; the remaining S-boxes S3..S8 are instantiated elsewhere.

Parameters:
- none (tables and widths are fixed by the DES standard)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  qualifies b1, b2 and p_in this cycle
- b1  input  6  S1 input; b1[5]=DES bit 1 (MSB)
- b2  input  6  S2 input; same bit order as b1
- p_in  input  32  P-box input; p_in[31]=DES bit 1, p_in[0]=DES bit 32
- s1_out  output  4  registered S1(b1); bit 3 = MSB
- s2_out  output  4  registered S2(b2)
- p_out  output  32  registered P(p_in); p_out[31]=DES bit 1
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset: on a rising clk with rst=1, s1_out, s2_out, p_out and out_valid all go to 0. Reset overrides in_valid. Reset mid-stream drops any in-flight result.
- Latency: exactly 1 cycle. On a rising clk with rst=0 and in_valid=1, the outputs load the lookup/permutation of the current inputs and out_valid goes to 1.
- Hold: when in_valid=0 (and rst=0), s1_out, s2_out and p_out keep their previous values and out_valid goes to 0.
- No backpressure; back-to-back valid inputs give back-to-back results.
- S-box indexing:
  - row = {b[5], b[0]} (0..3)
  - column = b[4:1] (0..15)
  - output = table[row][column] as 4 bits
- S1 rows (columns 0..15):
  - r0: 14 4 13 1 2 15 11 8 3 10 6 12 5 9 0 7
  - r1: 0 15 7 4 14 2 13 1 10 6 12 11 9 5 3 8
  - r2: 4 1 14 8 13 6 2 11 15 12 9 7 3 10 5 0
  - r3: 15 12 8 2 4 9 1 7 5 11 3 14 10 0 6 13
- S2 rows (columns 0..15):
  - r0: 15 1 8 14 6 11 3 4 9 7 2 13 12 0 5 10
  - r1: 3 13 4 7 15 2 8 14 12 0 1 10 6 9 11 5
  - r2: 0 14 7 11 10 4 13 1 5 8 12 6 9 3 2 15
  - r3: 13 8 10 1 3 15 4 2 11 6 7 12 0 5 14 9
- P permutation:
  - Numbering is DES style: bit 1 = MSB, bit 32 = LSB.
  - Output bit i takes input bit P[i], for i = 1..32.
  - P = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25
  - Pure wiring: a bijection with no inversion, so popcount(p_out) = popcount(p_in).
- The three functions are independent; any combination of input values is legal.
- The lookup and permutation logic is fully combinational ahead of the output registers. No X propagation for any 6-bit input.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 and nonzero inputs -> all outputs are 0; release rst, apply b1=0, b2=0 -> next cycle s1_out=14, s2_out=15, out_valid=1.
2. S-box corners:
   - b1=6'b111111 -> s1_out=13; b1=6'b000001 -> 0; b1=6'b100000 -> 4.
   - b2=6'b111111 -> s2_out=9; b2=6'b011011 -> 9.
   - Each result appears one cycle after input.
3. P single bits:
   - p_in=0x80000000 -> p_out=0x00800000.
   - p_in=0x00000001 -> p_out=0x00000800.
   - p_in=0xFFFFFFFF -> 0xFFFFFFFF; p_in=0 -> 0.
4. Exhaustive: all 64 values of b1 and b2 streamed back-to-back -> each output matches the golden tables, one cycle later, with out_valid continuously 1. Walking-one over all 32 p_in bits -> exactly one p_out bit set, at the position given by the P table.
5. Hold/valid: load b1=0 (s1_out=14), then drive in_valid=0 with b1=6'b111111 for 3 cycles -> s1_out stays 14 and out_valid=0.
6. Reset mid-stream: assert rst in the same cycle as a valid input -> the next cycle shows zeros; the following valid input is processed normally.
